// File: rtl/aqed_pkg.sv
// -----------------------------------------------------------------------------
// aqed_pkg
// Shared types and default sizing for the A-QED functional-consistency monitor.
//   aqed_state_t    : input-side FSM state (IDLE -> ORIG -> DUP)
//   AQED_DATA_W     : default stream data width
//   AQED_IDX_W      : default index / bound counter width
//   AQED_BOUND_MULT : default response-bound multiplier (bound = mult * depth)
// -----------------------------------------------------------------------------
package aqed_pkg;

  typedef enum logic [1:0] {
    AQED_IDLE = 2'd0,
    AQED_ORIG = 2'd1,
    AQED_DUP  = 2'd2
  } aqed_state_t;

  localparam int AQED_DATA_W     = 16;
  localparam int AQED_IDX_W      = 17;
  localparam int AQED_BOUND_MULT = 4;

endpackage

// File: rtl/aqed_bound_ctr.sv
// -----------------------------------------------------------------------------
// aqed_bound_ctr
// Counts DUT writes issued after the ORIGINAL tag and flags a response-bound
// violation when BOUND_MULT*depth writes have gone in without the ORIGINAL
// output having come back.
// Ports:
//   clk           clock
//   reset         synchronous active-low reset
//   clk_en_i      global enable; state holds when 0
//   active_i      ORIGINAL has been tagged (FSM not in IDLE)
//   wen_i         DUT write enable this cycle
//   depth_i       configured DUT depth
//   orig_done_i   ORIGINAL output already observed
//   bound_fail_o  sticky bound-violation flag
// -----------------------------------------------------------------------------
module aqed_bound_ctr
  import aqed_pkg::*;
#(
  parameter int IDX_W      = AQED_IDX_W,
  parameter int BOUND_MULT = AQED_BOUND_MULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en_i,
  input  logic        active_i,
  input  logic        wen_i,
  input  logic [15:0] depth_i,
  input  logic        orig_done_i,
  output logic        bound_fail_o
);

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] limit;
  logic             fail_q, fail_d;

  // Product is deliberately kept at IDX_W bits, same width as the counter.
  assign limit = IDX_W'(BOUND_MULT) * IDX_W'(depth_i);

  always_comb begin
    cnt_d  = cnt_q;
    fail_d = fail_q;
    // The tag cycle itself is excluded: active_i only rises the cycle after.
    if (active_i && wen_i && (cnt_q != '1)) cnt_d = cnt_q + IDX_W'(1);
    // Compare against the post-increment count so the flag lands right
    // after the write that reaches the bound.
    if (active_i && (cnt_d >= limit) && !orig_done_i) fail_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      fail_q <= 1'b0;
    end else if (clk_en_i) begin
      cnt_q  <= cnt_d;
      fail_q <= fail_d;
    end
  end

  assign bound_fail_o = fail_q;

endmodule

// File: rtl/aqed_fc_monitor.sv
// -----------------------------------------------------------------------------
// aqed_fc_monitor
// A-QED functional-consistency monitor for in-order streaming memory cores.
// Passes stimulus through to the DUT write port, tags one accepted input as
// ORIGINAL, later injects an identical DUPLICATE, and checks that the DUT
// returns equal data for both.
// Optional feature macro: AQED_BOUND_CHK_EN (response-bound check).
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   clk_en                global enable; all state holds when 0
//   src_valid/src_data    stimulus in;  src_ready low only in DUP inject cycle
//   exec_dup              tag ORIGINAL (in IDLE) / request DUPLICATE (in ORIG)
//   dut_wen/dut_wdata     DUT write port (combinational passthrough)
//   dut_valid/dut_rdata   DUT read port (1:1, in order with writes)
//   depth                 configured DUT depth, constant after reset
//   qed_done/qed_check    both outputs seen / they matched (sticky)
//   orig_done             ORIGINAL output seen (sticky)
//   bound_fail            response bound violated (sticky; 0 unless macro set)
// -----------------------------------------------------------------------------
module aqed_fc_monitor
  import aqed_pkg::*;
#(
  parameter int DATA_W     = AQED_DATA_W,
  parameter int IDX_W      = AQED_IDX_W,
  parameter int BOUND_MULT = AQED_BOUND_MULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  input  logic              exec_dup,
  output logic              dut_wen,
  output logic [DATA_W-1:0] dut_wdata,
  input  logic              dut_valid,
  input  logic [DATA_W-1:0] dut_rdata,
  input  logic [15:0]       depth,
  output logic              qed_done,
  output logic              qed_check,
  output logic              orig_done,
  output logic              bound_fail
);

  aqed_state_t       state_q, state_d;
  logic [IDX_W-1:0]  in_idx_q, in_idx_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [IDX_W-1:0]  orig_idx_q, orig_idx_d;
  logic [IDX_W-1:0]  dup_idx_q, dup_idx_d;
  logic [DATA_W-1:0] orig_data_q, orig_data_d;
  logic [DATA_W-1:0] orig_out_q, orig_out_d;
  logic              orig_done_q, orig_done_d;
  logic              qed_done_q, qed_done_d;
  logic              qed_check_q, qed_check_d;

  logic              tag, inject;
  logic [IDX_W-1:0]  orig_idx_eff, dup_idx_eff;

  // NOTE: every signal assigned here gets its default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    in_idx_d    = in_idx_q;
    out_idx_d   = out_idx_q;
    orig_idx_d  = orig_idx_q;
    dup_idx_d   = dup_idx_q;
    orig_data_d = orig_data_q;
    orig_out_d  = orig_out_q;
    orig_done_d = orig_done_q;
    qed_done_d  = qed_done_q;
    qed_check_d = qed_check_q;
    tag         = 1'b0;
    inject      = 1'b0;
    src_ready   = 1'b1;
    dut_wen     = src_valid;
    dut_wdata   = src_data;

    unique case (state_q)
      AQED_IDLE: begin
        if (src_valid && exec_dup) begin
          tag         = 1'b1;
          orig_data_d = src_data;
          orig_idx_d  = in_idx_q;
          state_d     = AQED_ORIG;
        end
      end
      AQED_ORIG: begin
        // Injection steals the write port for one cycle; the source sees
        // src_ready low and must hold its data. Gated by clk_en so a frozen
        // monitor never pushes repeated copies into the DUT.
        if (exec_dup && clk_en) begin
          inject    = 1'b1;
          src_ready = 1'b0;
          dut_wen   = 1'b1;
          dut_wdata = orig_data_q;
          dup_idx_d = in_idx_q;
          state_d   = AQED_DUP;
        end
      end
      AQED_DUP: ;
      default: state_d = AQED_IDLE;
    endcase

    // Saturating indices: once pinned at all-ones, later traffic cannot
    // alias back onto a tagged index.
    if (dut_wen && (in_idx_q != '1))    in_idx_d  = in_idx_q + IDX_W'(1);
    if (dut_valid && (out_idx_q != '1)) out_idx_d = out_idx_q + IDX_W'(1);

    // Same-cycle tag/inject with a zero-latency DUT: compare against the
    // index being captured this cycle rather than the stale register.
    orig_idx_eff = tag    ? in_idx_q : orig_idx_q;
    dup_idx_eff  = inject ? in_idx_q : dup_idx_q;

    if (dut_valid && !orig_done_q && (tag || state_q != AQED_IDLE) &&
        (out_idx_q == orig_idx_eff)) begin
      orig_out_d  = dut_rdata;
      orig_done_d = 1'b1;
    end

    // DUPLICATE output is always later than ORIGINAL's, so orig_out_q is
    // already valid whenever this fires.
    if (dut_valid && orig_done_q && !qed_done_q &&
        (inject || state_q == AQED_DUP) && (out_idx_q == dup_idx_eff)) begin
      qed_done_d  = 1'b1;
      qed_check_d = (dut_rdata == orig_out_q);
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= AQED_IDLE;
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      orig_idx_q  <= '0;
      dup_idx_q   <= '0;
      // NOTE: captured data registers are reset as well; they are plain
      // flops, not a RAM, and a known value simplifies debug.
      orig_data_q <= '0;
      orig_out_q  <= '0;
      orig_done_q <= 1'b0;
      qed_done_q  <= 1'b0;
      qed_check_q <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      in_idx_q    <= in_idx_d;
      out_idx_q   <= out_idx_d;
      orig_idx_q  <= orig_idx_d;
      dup_idx_q   <= dup_idx_d;
      orig_data_q <= orig_data_d;
      orig_out_q  <= orig_out_d;
      orig_done_q <= orig_done_d;
      qed_done_q  <= qed_done_d;
      qed_check_q <= qed_check_d;
    end
  end

  assign orig_done = orig_done_q;
  assign qed_done  = qed_done_q;
  assign qed_check = qed_check_q;

`ifdef AQED_BOUND_CHK_EN
  aqed_bound_ctr #(
    .IDX_W      (IDX_W),
    .BOUND_MULT (BOUND_MULT)
  ) u_bound_ctr (
    .clk          (clk),
    .reset        (reset),
    .clk_en_i     (clk_en),
    .active_i     (state_q != AQED_IDLE),
    .wen_i        (dut_wen),
    .depth_i      (depth),
    .orig_done_i  (orig_done_q),
    .bound_fail_o (bound_fail)
  );
`else
  // Bound check compiled out: depth and BOUND_MULT have no consumer.
  logic [31:0] unused_cfg;
  assign unused_cfg = {depth, 16'(BOUND_MULT)};
  assign bound_fail = 1'b0;
`endif

endmodule

// File: tb/tb_aqed_fc_monitor.sv
// -----------------------------------------------------------------------------
// tb_aqed_fc_monitor
// Self-checking bench for aqed_fc_monitor. A small behavioural DUT (2-cycle
// delay line with optional corruption / stall) sits on the monitor's write
// port; a queue holds the data the DUT is expected to return. A second
// instance (DATA_W=32, IDX_W=8) with a zero-latency loopback exercises
// counter saturation.
// -----------------------------------------------------------------------------
module tb_aqed_fc_monitor;
  import aqed_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;
  logic        exec_dup;
  logic        dut_wen;
  logic [15:0] dut_wdata;
  logic        dut_valid;
  logic [15:0] dut_rdata;
  logic [15:0] depth;
  logic        qed_done, qed_check, orig_done, bound_fail;

  logic        s6_valid;
  logic [31:0] s6_data;
  logic        s6_ready, s6_exec_dup, s6_wen;
  logic [31:0] s6_wdata;
  logic        s6_qed_done, s6_qed_check, s6_orig_done, s6_bound_fail;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  int          wr_cnt;
  int          corrupt_at = -1;
  logic        stall = 1'b0;

  // Behavioural DUT: two-stage delay line.
  logic        p1v, p2v;
  logic [15:0] p1d, p2d;
  int          out_n;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      p1v <= 1'b0; p1d <= '0; p2v <= 1'b0; p2d <= '0; out_n <= 0;
    end else begin
      p1v   <= dut_wen & ~stall;
      p1d   <= dut_wdata;
      p2v   <= p1v;
      p2d   <= (p1v && out_n == corrupt_at) ? 16'hDEAD : p1d;
      out_n <= out_n + (p1v ? 1 : 0);
    end
  end

  assign dut_valid = p2v;
  assign dut_rdata = p2d;

  aqed_fc_monitor u_dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .exec_dup   (exec_dup),
    .dut_wen    (dut_wen),
    .dut_wdata  (dut_wdata),
    .dut_valid  (dut_valid),
    .dut_rdata  (dut_rdata),
    .depth      (depth),
    .qed_done   (qed_done),
    .qed_check  (qed_check),
    .orig_done  (orig_done),
    .bound_fail (bound_fail)
  );

  aqed_fc_monitor #(.DATA_W(32), .IDX_W(8)) u_dut6 (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .src_valid  (s6_valid),
    .src_data   (s6_data),
    .src_ready  (s6_ready),
    .exec_dup   (s6_exec_dup),
    .dut_wen    (s6_wen),
    .dut_wdata  (s6_wdata),
    .dut_valid  (s6_wen),
    .dut_rdata  (s6_wdata),
    .depth      (16'd1),
    .qed_done   (s6_qed_done),
    .qed_check  (s6_qed_check),
    .orig_done  (s6_orig_done),
    .bound_fail (s6_bound_fail)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; src_valid = 1'b0; src_data = '0; exec_dup = 1'b0;
    s6_valid = 1'b0; s6_data = '0; s6_exec_dup = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    wr_cnt = 0;
  endtask

  // One cycle of stimulus: pops/compares any DUT output, drives inputs at
  // the falling edge, compares the combinational write port, and pushes the
  // data the DUT is expected to return for this write.
  task automatic drive(input string nm, input logic v, input logic [15:0] d,
                       input logic dup, input logic exp_wen,
                       input logic [15:0] exp_wd, input logic exp_rdy);
    logic [15:0] e;
    @(negedge clk);
    if (dut_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s_rdata: DUT output %h with nothing expected", nm, dut_rdata);
      end else begin
        e = exp_q.pop_front();
        if (dut_rdata !== e) begin
          n_bad++;
          $display("FAIL %s_rdata: got %h expected %h", nm, dut_rdata, e);
        end
      end
    end
    src_valid = v; src_data = d; exec_dup = dup;
    #1;
    n_cmp++;
    if (src_ready !== exp_rdy) begin
      n_bad++;
      $display("FAIL %s_ready: got %b expected %b", nm, src_ready, exp_rdy);
    end
    n_cmp++;
    if (dut_wen !== exp_wen) begin
      n_bad++;
      $display("FAIL %s_wen: got %b expected %b", nm, dut_wen, exp_wen);
    end
    if (exp_wen) begin
      n_cmp++;
      if (dut_wdata !== exp_wd) begin
        n_bad++;
        $display("FAIL %s_wdata: got %h expected %h", nm, dut_wdata, exp_wd);
      end
      if (!stall) exp_q.push_back((wr_cnt == corrupt_at) ? 16'hDEAD : exp_wd);
      wr_cnt++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({qed_done, qed_check, orig_done, bound_fail, dut_wen} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {qed_done, qed_check, orig_done, bound_fail, dut_wen});
    end
    n_cmp++;
    if (u_dut.state_q !== AQED_IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d expected %0d", u_dut.state_q, AQED_IDLE);
    end
  endtask

  // Inputs 1..8, ORIGINAL = input 3, DUPLICATE injected after input 5.
  task automatic test_stream(input bit corrupt);
    string nm;
    nm = corrupt ? "corrupt" : "stream";
    do_reset();
    corrupt_at = corrupt ? 5 : -1;
    for (int j = 0; j < 12; j++) begin
      logic v, dup, rdy;
      logic [15:0] d, ewd;
      v   = (j < 9);
      dup = (j == 2) || (j == 5);
      rdy = (j != 5);
      d   = !v ? 16'd0 : (j < 5) ? 16'(j + 1) : (j == 5) ? 16'd6 : 16'(j);
      ewd = (j == 5) ? 16'd3 : d;
      drive(nm, v, d, dup, v, ewd, rdy);
      if (j == 4) begin
        n_cmp++;
        if (orig_done !== 1'b0) begin
          n_bad++; $display("FAIL %s_orig_early: got %b expected 0", nm, orig_done);
        end
      end
      if (j == 5) begin
        n_cmp++;
        if ({orig_done, qed_done} !== 2'b10) begin
          n_bad++; $display("FAIL %s_orig_done: got %b expected 10", nm, {orig_done, qed_done});
        end
      end
      if (j == 7) begin
        n_cmp++;
        if (qed_done !== 1'b0) begin
          n_bad++; $display("FAIL %s_qed_early: got %b expected 0", nm, qed_done);
        end
      end
      if (j == 8) begin
        n_cmp++;
        if ({qed_done, qed_check} !== {1'b1, !corrupt}) begin
          n_bad++;
          $display("FAIL %s_qed: got %b expected %b", nm, {qed_done, qed_check}, {1'b1, !corrupt});
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL %s_drain: got %0d left expected 0", nm, exp_q.size());
    end
    corrupt_at = -1;
  endtask

  // exec_dup held high from the first input: ORIGINAL = first write,
  // DUPLICATE = second write, src_ready low only in that cycle.
  task automatic test_back_to_back();
    do_reset();
    drive("b2b0", 1'b1, 16'h0011, 1'b1, 1'b1, 16'h0011, 1'b1);
    drive("b2b1", 1'b1, 16'h0022, 1'b1, 1'b1, 16'h0011, 1'b0);
    drive("b2b2", 1'b1, 16'h0022, 1'b1, 1'b1, 16'h0022, 1'b1);
    drive("b2b3", 1'b1, 16'h0033, 1'b1, 1'b1, 16'h0033, 1'b1);
    for (int j = 0; j < 3; j++) drive("b2b_idle", 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    n_cmp++;
    if ({orig_done, qed_done, qed_check} !== 3'b111) begin
      n_bad++; $display("FAIL b2b_flags: got %b expected 111", {orig_done, qed_done, qed_check});
    end
  endtask

  // DUT never answers: after 8 writes past the tag the bound (4*2) trips.
  task automatic test_bound();
    logic exp_fail;
`ifdef AQED_BOUND_CHK_EN
    exp_fail = 1'b1;
`else
    exp_fail = 1'b0;
`endif
    do_reset();
    stall = 1'b1;
    drive("bound_tag", 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0100, 1'b1);
    for (int j = 1; j <= 8; j++)
      drive("bound_wr", 1'b1, 16'(16'h0100 + j), 1'b0, 1'b1, 16'(16'h0100 + j), 1'b1);
    n_cmp++;
    if (bound_fail !== 1'b0) begin
      n_bad++; $display("FAIL bound_early: got %b expected 0", bound_fail);
    end
    drive("bound_idle", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_cmp++;
    if ({bound_fail, orig_done} !== {exp_fail, 1'b0}) begin
      n_bad++;
      $display("FAIL bound_fail: got %b expected %b", {bound_fail, orig_done}, {exp_fail, 1'b0});
    end
    stall = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive("mid_tag", 1'b1, 16'h0050, 1'b1, 1'b1, 16'h0050, 1'b1);
    for (int j = 0; j < 3; j++) drive("mid_idle", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_cmp++;
    if (orig_done !== 1'b1) begin
      n_bad++; $display("FAIL mid_orig_done: got %b expected 1", orig_done);
    end
    @(negedge clk);
    reset = 1'b0; exec_dup = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({qed_done, qed_check, orig_done, bound_fail} !== 4'b0 || u_dut.state_q !== AQED_IDLE) begin
      n_bad++;
      $display("FAIL mid_reset: got flags %b state %0d expected 0000 state 0",
               {qed_done, qed_check, orig_done, bound_fail}, u_dut.state_q);
    end
    reset = 1'b1;
    exp_q.delete();
    wr_cnt = 0;
    drive("mid_retag", 1'b1, 16'h0060, 1'b1, 1'b1, 16'h0060, 1'b1);
    drive("mid_dup",   1'b1, 16'h0061, 1'b1, 1'b1, 16'h0060, 1'b0);
    for (int j = 0; j < 3; j++) drive("mid_flush", 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_cmp++;
    if ({qed_done, qed_check} !== 2'b11) begin
      n_bad++; $display("FAIL mid_qed: got %b expected 11", {qed_done, qed_check});
    end
  endtask

  // 300 untagged inputs on the 8-bit-index instance: indices pin at 255.
  task automatic test_saturate();
    int bad_wd;
    do_reset();
    bad_wd = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      s6_valid = 1'b1; s6_data = 32'(i) ^ 32'hA5A5_0000;
      #1;
      if (s6_wdata !== (32'(i) ^ 32'hA5A5_0000)) bad_wd++;
    end
    @(negedge clk);
    s6_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bad_wd != 0) begin
      n_bad++; $display("FAIL sat_wdata: got %0d bad cycles expected 0", bad_wd);
    end
    n_cmp++;
    if (u_dut6.in_idx_q !== 8'hFF || u_dut6.out_idx_q !== 8'hFF) begin
      n_bad++;
      $display("FAIL sat_idx: got in %h out %h expected ff ff", u_dut6.in_idx_q, u_dut6.out_idx_q);
    end
    n_cmp++;
    if ({s6_orig_done, s6_qed_done, s6_qed_check, s6_bound_fail} !== 4'b0) begin
      n_bad++;
      $display("FAIL sat_flags: got %b expected 0000",
               {s6_orig_done, s6_qed_done, s6_qed_check, s6_bound_fail});
    end
  endtask

  initial begin
    reset = 1'b0; clk_en = 1'b1; depth = 16'd2;
    src_valid = 1'b0; src_data = '0; exec_dup = 1'b0;
    s6_valid = 1'b0; s6_data = '0; s6_exec_dup = 1'b0;
    wr_cnt = 0;
    test_reset();
    test_stream(1'b0);
    test_stream(1'b1);
    test_back_to_back();
    test_bound();
    test_mid_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
